// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide engine that drives the external 16-bit ALU one op per cycle.
// Optional macro MULDIV_ZERO_SKIP_EN: trivially-zero operands finish without iterating.
module muldiv_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_SIZE    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] alu_rega,
    output logic [DATA_WIDTH-1:0] alu_regb,
    output logic [OP_SIZE-1:0]    alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cout
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [OP_SIZE-1:0] ALU_ADD  = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] ALU_SUB  = OP_SIZE'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt_q;
    logic                  op_q;
    logic [DATA_WIDTH-1:0] opd_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q;
    logic [DATA_WIDTH-1:0] hi_nxt, lo_nxt;
    logic [DATA_WIDTH-1:0] div_shift;
    logic                  accept;
    logic                  dbz_hit;
    logic                  skip_hit;
    logic                  last_iter;

    assign accept    = (state == IDLE) && start;
    assign dbz_hit   = op && (opb == '0);
    assign last_iter = (state == RUN) && (cnt_q == CNT_LAST);
    assign div_shift = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};

`ifdef MULDIV_ZERO_SKIP_EN
    assign skip_hit = (!op && ((opa == '0) || (opb == '0))) ||
                      (op && (opa == '0) && (opb != '0));
`else
    assign skip_hit = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt   = state;
        alu_control = ALU_ADD;
        alu_rega    = '0;
        alu_regb    = '0;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (dbz_hit || skip_hit) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!op_q) begin
                    alu_rega = hi_q;
                    alu_regb = lo_q[0] ? opd_q : '0;
                    {hi_nxt, lo_nxt} = {alu_cout, alu_out, lo_q[DATA_WIDTH-1:1]};
                end else begin
                    alu_control = ALU_SUB;
                    alu_rega    = div_shift;
                    alu_regb    = opd_q;
                    // A set shifted-out msb means the partial remainder exceeds any divisor.
                    if (hi_q[DATA_WIDTH-1] || !alu_cout) begin
                        hi_nxt = alu_out;
                        lo_nxt = {lo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        hi_nxt = div_shift;
                        lo_nxt = {lo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt_q       <= '0;
                div_by_zero <= dbz_hit;
                if (dbz_hit) begin
                    result_hi <= opa;
                    result_lo <= '1;
                end else if (skip_hit) begin
                    result_hi <= '0;
                    result_lo <= '0;
                end
            end else if (state == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (last_iter) begin
                    result_hi <= hi_nxt;
                    result_lo <= lo_nxt;
                end
            end
        end
    end

    // Operand and working registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op;
            opd_q <= op ? opb : opa;
            hi_q  <= '0;
            lo_q  <= op ? opa : opb;
        end else if (state == RUN) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural ADD/SUB ALU attached.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] opa, opb;
    logic        busy, done, div_by_zero;
    logic [15:0] result_hi, result_lo;
    logic [15:0] alu_rega, alu_regb, alu_out;
    logic [3:0]  alu_control;
    logic        alu_cout;
    logic [16:0] alu_full;

    muldiv_seq #(.DATA_WIDTH(16), .OP_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero), .alu_rega(alu_rega), .alu_regb(alu_regb),
        .alu_control(alu_control), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (alu_control == 4'd1) alu_full = {1'b0, alu_rega} - {1'b0, alu_regb};
        else                     alu_full = {1'b0, alu_rega} + {1'b0, alu_regb};
    end
    assign alu_out  = alu_full[15:0];
    assign alu_cout = alu_full[16];

`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 17;
`endif

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   rst_req = 0;
    int   rst_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sole owner of the comparison counters.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                chk("reset_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
                chk("reset_results", {32'd0, result_hi, result_lo}, 64'd0);
                chk("reset_alu", {28'd0, alu_control, alu_rega, alu_regb}, 64'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", 64'(result_hi), 64'(e.hi));
                    chk("result_lo", 64'(result_lo), 64'(e.lo));
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    chk("done_latency", 64'(cyc - e.issue), 64'(e.lat));
                    chk("busy_in_done", 64'(busy), 64'd1);
                    chk("alu_idle_in_done", {28'd0, alu_control, alu_rega, alu_regb}, 64'd0);
                end
            end else if (sb.size() > 0 && (cyc - sb[0].issue) > 40) begin
                e = sb.pop_front();
                chk("done_timeout", 64'd0, 64'd1);
            end
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    endtask

    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eh, input logic [15:0] el, input logic ed,
                         input int lat, input bit push);
        exp_t e;
        wait_idle();
        start = 1'b1; op = o; opa = a; opb = b;
        if (push) begin
            e = '{hi: eh, lo: el, dbz: ed, issue: cyc, lat: lat};
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        opa = 16'($urandom);
        opb = 16'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got no summary");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1 rst_req++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 16'h1234, 16'h0056, 16'h0006, 16'h1D78, 1'b0, 17, 1'b1);
        issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, 1'b1);
        issue(1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0, 17, 1'b1);
        issue(1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17, 1'b1);
        issue(1'b1, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1, 1, 1'b1);
        issue(1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17, 1'b1);
        issue(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17, 1'b1);
        issue(1'b1, 16'h0007, 16'h0010, 16'h0007, 16'h0000, 1'b0, 17, 1'b1);
        issue(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, ZLAT, 1'b1);
        issue(1'b1, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, ZLAT, 1'b1);
        drain();

        // start held across DONE: ignored there, accepted again once back in IDLE
        wait_idle();
        start = 1'b1; op = 1'b1; opa = 16'h0055; opb = 16'h0000;
        e = '{hi: 16'h0055, lo: 16'hFFFF, dbz: 1'b1, issue: cyc, lat: 1};
        sb.push_back(e);
        e.issue = cyc + 2;
        sb.push_back(e);
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();

        // start pulse in cycle 5 of a running multiply must be ignored
        issue(1'b0, 16'h1234, 16'h0056, 16'h0006, 16'h1D78, 1'b0, 17, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 16'hFFFF; opb = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        drain();

        // asynchronous reset in cycle 9 aborts the op with no done pulse
        issue(1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 17, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        rst_req++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        issue(1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer that acts as the master of the 16-bit datapath ALU.
- It drives the ALU operand and control inputs, then consumes the ALU result and carry each cycle.
- It implements shift-add multiplication and restoring division, with one ALU operation per cycle.
- It sits beside the ALU in the execute stage and serves MULT/DIV instructions with a start/done handshake.

Parameters:
- DATA_WIDTH, 16, operand/result width; must match the ALU DATA_WIDTH.
- OP_SIZE, 4, width of the ALU control code.

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = unsigned multiply, 1 = unsigned divide.
- opa  input  DATA_WIDTH  multiplicand or dividend.
- opb  input  DATA_WIDTH  multiplier or divisor.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- result_hi  output  DATA_WIDTH  product high half, or remainder.
- result_lo  output  DATA_WIDTH  product low half, or quotient.
- div_by_zero  output  1  divide with opb = 0; valid with done, held until the next accepted start.
- alu_rega  output  DATA_WIDTH  ALU operand A.
- alu_regb  output  DATA_WIDTH  ALU operand B.
- alu_control  output  OP_SIZE  ALU opcode; only 0 (ADD) and 1 (SUB) are used.
- alu_out  input  DATA_WIDTH  ALU result (combinational return).
- alu_cout  input  1  ALU bit DATA_WIDTH; carry for ADD, borrow for SUB (1 when A < B).

Behaviour:
- Reset (async, rst_n low) clears all outputs:
  - state = IDLE; busy = done = div_by_zero = 0; result_hi = result_lo = 0.
  - alu_rega = alu_regb = 0; alu_control = 0.
- States: IDLE, RUN, DONE. Cycle numbering: the cycle in which start is sampled high in IDLE is cycle 0.
- IDLE, start = 1:
  - Latch opa and opb; clear the iteration counter.
  - op = 1 and opb = 0 goes straight to DONE: div_by_zero = 1, result_hi = opa, result_lo = all ones. done is high in cycle 1.
  - Otherwise go to RUN.
- IDLE, start = 0: stay in IDLE.
- Multiply (RUN, DATA_WIDTH iterations, cycles 1..DATA_WIDTH):
  - Registers: hi starts at 0; lo starts at opb.
  - Drive alu_control = ADD, alu_rega = hi, alu_regb = lo[0] ? mcand : 0.
  - Each edge: {hi, lo} <= {alu_cout, alu_out, lo[DATA_WIDTH-1:1]}.
- Divide (RUN, DATA_WIDTH iterations):
  - Registers: R starts at 0; Q starts at opa.
  - Let msb = R[DATA_WIDTH-1]. Drive alu_control = SUB, alu_rega = {R[DATA_WIDTH-2:0], Q[DATA_WIDTH-1]}, alu_regb = divisor.
  - If msb = 1 or alu_cout = 0: R <= alu_out and shift a 1 into Q.
  - Else: R <= alu_rega and shift a 0 into Q.
  - The msb = 1 case is correct because the true difference fits in DATA_WIDTH bits and alu_out is exact modulo 2^DATA_WIDTH.
- After the DATA_WIDTH-th iteration edge, go to DONE:
  - done is high in cycle DATA_WIDTH+1 (cycle 17 at the default width), for exactly one cycle.
  - result_hi/result_lo are updated at the same edge and held until the next accepted start.
- DONE always returns to IDLE on the next edge.
- Reset behaviour:
  - Operand registers do not reset (results do).
  - Reset mid-RUN aborts: results read 0, and no done pulse follows.
- start while busy is ignored, with no queuing. start in the same cycle that DONE exits is also ignored; it is accepted the cycle after.
- ALU outputs in IDLE/DONE: control = ADD, both operands 0.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined:
  - Multiply with opa = 0 or opb = 0 skips RUN: goes IDLE→DONE with result_hi = result_lo = 0, done in cycle 1.
  - Divide with opa = 0 and opb ≠ 0 also skips RUN: quotient 0, remainder 0, done in cycle 1.
- Undefined: these cases run all DATA_WIDTH iterations; results are identical, and done comes in cycle DATA_WIDTH+1.
- Divide by zero behaves the same either way.

Test Plan:
- Multiply 0x1234 × 0x0056 -> done in cycle 17: result_hi = 0x0006, result_lo = 0x1D78, div_by_zero = 0.
- Multiply 0xFFFF × 0xFFFF -> result_hi = 0xFFFE, result_lo = 0x0001; alu_cout is exercised on the final iterations.
- Divide 0x03E8 ÷ 0x0007 -> result_lo = 0x008E, result_hi = 0x0006. Then divide 0xFFFF ÷ 0x8001 -> result_lo = 0x0001, result_hi = 0x7FFE (msb path).
- Divide 0x00AB ÷ 0x0000 -> done in cycle 1: div_by_zero = 1, result_hi = 0x00AB, result_lo = 0xFFFF.
- Start a multiply; pulse start again in cycle 5 with other operands; assert rst_n = 0 in cycle 9 of a second op:
  - The cycle-5 start is ignored, and the first result is unaffected.
  - On reset, outputs clear asynchronously, no done pulse follows, and the next start runs normally.
- Multiply 0x0000 × 0x1234 -> done in cycle 1 with MULDIV_ZERO_SKIP_EN defined, or cycle 17 without it; results 0x0000/0x0000 either way.
